// File: rtl/exe_multicycle_ctrl.sv
// Execute-stage sequencer for the shared iterative MUL/SIN/COS unit: latches the
// operation, launches the unit, stalls the pipeline and hands a one-cycle result to writeback.
module exe_multicycle_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              flush_i,
  output logic              unit_start_o,
  output logic              unit_abort_o,
  output logic [1:0]        unit_op_o,
  output logic [DATA_W-1:0] unit_a_o,
  output logic [DATA_W-1:0] unit_b_o,
  input  logic              unit_done_i,
  input  logic [DATA_W-1:0] unit_result_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] result_o,
  output logic              result_valid_o,
  output logic              err_o,
  input  logic              err_clr_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MAX_CYCLES - 1);

  state_e            r_state, w_state_d;
  logic [1:0]        r_op, w_op_d;
  logic [DATA_W-1:0] r_a, w_a_d;
  logic [DATA_W-1:0] r_b, w_b_d;
  logic [DATA_W-1:0] r_result, w_result_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic              r_err, w_err_d;
  logic              w_accept;
  logic              w_timeout;

  assign w_accept = req_i && (op_i != 2'b00) && !flush_i;

  always_comb begin
    w_state_d      = r_state;
    w_op_d         = r_op;
    w_a_d          = r_a;
    w_b_d          = r_b;
    w_result_d     = r_result;
    w_cnt_d        = r_cnt;
    w_timeout      = 1'b0;
    unit_start_o   = 1'b0;
    unit_abort_o   = 1'b0;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;

    unique case (r_state)
      StIdle: begin
        stall_o = w_accept;
        if (w_accept) begin
          w_op_d    = op_i;
          w_a_d     = a_i;
          w_b_d     = b_i;
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        stall_o = 1'b1;
        w_cnt_d = '0;
        if (flush_i) begin
          w_state_d = StIdle;
        end else begin
          unit_start_o = 1'b1;
          w_state_d    = StWait;
        end
      end
      StWait: begin
        stall_o = 1'b1;
        w_cnt_d = r_cnt + 1'b1;
        // Flush beats done, and done beats the watchdog.
        if (flush_i) begin
          unit_abort_o = 1'b1;
          w_state_d    = StIdle;
        end else if (unit_done_i) begin
          w_result_d = unit_result_i;
          w_state_d  = StDone;
        end else if (r_cnt == CntLast) begin
          w_timeout    = 1'b1;
          unit_abort_o = 1'b1;
          w_result_d   = '0;
          w_state_d    = StDone;
        end
      end
      StDone: begin
        // The held request is the instruction just serviced, so it is not re-accepted.
        result_valid_o = !flush_i;
        w_state_d      = StIdle;
      end
    endcase

    w_err_d = w_timeout | (r_err & ~err_clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_op     <= 2'b00;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_op     <= w_op_d;
      r_a      <= w_a_d;
      r_b      <= w_b_d;
      r_result <= w_result_d;
      r_cnt    <= w_cnt_d;
      r_err    <= w_err_d;
    end
  end

  assign unit_op_o = r_op;
  assign unit_a_o  = r_a;
  assign unit_b_o  = r_b;
  assign result_o  = r_result;
  assign err_o     = r_err;

endmodule

// File: tb/tb_exe_multicycle_ctrl.sv
// Bench for exe_multicycle_ctrl: behavioural unit responder plus a result scoreboard.
module tb_exe_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush_i = 1'b0;
  logic        unit_start_o;
  logic        unit_abort_o;
  logic [1:0]  unit_op_o;
  logic [31:0] unit_a_o;
  logic [31:0] unit_b_o;
  logic        unit_done_i = 1'b0;
  logic [31:0] unit_result_i = '0;
  logic        stall_o;
  logic [31:0] result_o;
  logic        result_valid_o;
  logic        err_o;
  logic        err_clr_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] sb_q[$];

  int          rsp_delay = 10000;
  logic [31:0] rsp_val = '0;
  bit          rsp_pend = 1'b0;
  int          rsp_cnt = 0;

  exe_multicycle_ctrl #(
    .DATA_W    (32),
    .MAX_CYCLES(32),
    .CNT_W     (6)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .op_i          (op_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .flush_i       (flush_i),
    .unit_start_o  (unit_start_o),
    .unit_abort_o  (unit_abort_o),
    .unit_op_o     (unit_op_o),
    .unit_a_o      (unit_a_o),
    .unit_b_o      (unit_b_o),
    .unit_done_i   (unit_done_i),
    .unit_result_i (unit_result_i),
    .stall_o       (stall_o),
    .result_o      (result_o),
    .result_valid_o(result_valid_o),
    .err_o         (err_o),
    .err_clr_i     (err_clr_i)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Unit model: sees start at negedge, raises done for one cycle rsp_delay cycles later.
  always @(negedge clk) begin
    if (!rst_n) begin
      rsp_pend = 1'b0;
    end else if (unit_start_o) begin
      rsp_pend = 1'b1;
      rsp_cnt  = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    unit_done_i = 1'b0;
    if (rsp_pend) begin
      rsp_cnt++;
      if (rsp_cnt == rsp_delay) begin
        unit_done_i   = 1'b1;
        unit_result_i = rsp_val;
        rsp_pend      = 1'b0;
      end else if (rsp_cnt > rsp_delay) begin
        rsp_pend = 1'b0;
      end
    end
  end

  // Scoreboard: every result_valid_o must match the oldest expected {err, result}.
  always @(negedge clk) begin
    if (rst_n && result_valid_o) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_valid", 64'(result_o), 64'hdead_0000);
      end else begin
        logic [32:0] exp;
        exp = sb_q.pop_front();
        check_eq("sb_result", 64'(result_o), 64'(exp[31:0]));
        check_eq("sb_err", 64'(err_o), 64'(exp[32]));
      end
    end
  end

  // One full operation with req_i held until the DONE cycle; valid expected at cycle exp_lat.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int dly, input logic [31:0] res,
                        input logic exp_err, input int clr_cyc, input int exp_lat,
                        input int exp_abort);
    int starts = 0;
    int stalls = 0;
    int start_cyc = -1;
    int valid_cyc = -1;
    int abort_cyc = -1;
    sb_q.push_back({exp_err, res});
    rsp_delay = dly;
    rsp_val   = res;
    for (int c = 0; c < 100 && valid_cyc < 0; c++) begin
      @(posedge clk); #1;
      req_i = 1'b1; op_i = op; a_i = a; b_i = b;
      err_clr_i = (c == clr_cyc);
      @(negedge clk);
      if (stall_o) stalls++;
      if (unit_start_o) begin starts++; start_cyc = c; end
      if (unit_abort_o) abort_cyc = c;
      if (c == 2) begin
        check_eq({tag, "_unit_op"}, 64'(unit_op_o), 64'(op));
        check_eq({tag, "_unit_a"}, 64'(unit_a_o), 64'(a));
        check_eq({tag, "_unit_b"}, 64'(unit_b_o), 64'(b));
      end
      if (result_valid_o) valid_cyc = c;
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      req_i = 1'b0; op_i = 2'b00; err_clr_i = 1'b0;
      @(negedge clk);
      if (stall_o) stalls++;
      if (unit_start_o) starts++;
    end
    check_eq({tag, "_starts"}, 64'(starts), 64'd1);
    check_eq({tag, "_start_cyc"}, 64'(start_cyc), 64'd1);
    check_eq({tag, "_valid_cyc"}, 64'(valid_cyc), 64'(exp_lat));
    check_eq({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_lat));
    check_eq({tag, "_abort_cyc"}, 64'(abort_cyc), 64'(exp_abort));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ctrl", 64'({stall_o, unit_start_o, unit_abort_o, result_valid_o, err_o}), 64'd0);
    check_eq("rst_result", 64'(result_o), 64'd0);
    rst_n = 1'b1;

    // MUL 7*6, done 4 cycles after start.
    run_op("mul", 2'b01, 32'd7, 32'd6, 4, 32'd42, 1'b0, -1, 6, -1);
    check_eq("mul_err", 64'(err_o), 64'd0);

    // SIN with req_i held through DONE.
    run_op("sin", 2'b10, 32'h4000, 32'h0, 3, 32'h2D41, 1'b0, -1, 5, -1);

    // req_i with op 00 is not accepted.
    @(posedge clk); #1; req_i = 1'b1; op_i = 2'b00;
    @(negedge clk);
    check_eq("nop_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1; req_i = 1'b0;
    @(negedge clk);
    check_eq("nop_start", 64'(unit_start_o), 64'd0);

    // Flush during ISSUE.
    rsp_delay = 2;
    @(posedge clk); #1; req_i = 1'b1; op_i = 2'b01; a_i = 32'd1; b_i = 32'd1;
    @(negedge clk);
    check_eq("fli_stall0", 64'(stall_o), 64'd1);
    @(posedge clk); #1; flush_i = 1'b1;
    @(negedge clk);
    check_eq("fli_start", 64'(unit_start_o), 64'd0);
    check_eq("fli_abort", 64'(unit_abort_o), 64'd0);
    check_eq("fli_stall1", 64'(stall_o), 64'd1);
    @(posedge clk); #1; flush_i = 1'b0; req_i = 1'b0; op_i = 2'b00;
    @(negedge clk);
    check_eq("fli_stall2", 64'(stall_o), 64'd0);
    check_eq("fli_start2", 64'(unit_start_o), 64'd0);

    // Flush mid-WAIT; the unit's late done lands in IDLE and must be ignored.
    rsp_delay = 6; rsp_val = 32'h5555;
    @(posedge clk); #1; req_i = 1'b1; op_i = 2'b01; a_i = 32'd2; b_i = 32'd3;
    repeat (3) @(posedge clk);
    #1; flush_i = 1'b1;
    @(negedge clk);
    check_eq("flw_abort", 64'(unit_abort_o), 64'd1);
    check_eq("flw_stall", 64'(stall_o), 64'd1);
    @(posedge clk); #1; flush_i = 1'b0; req_i = 1'b0; op_i = 2'b00;
    begin
      int bad = 0;
      for (int c = 0; c < 7; c++) begin
        @(negedge clk);
        if (stall_o || unit_start_o || unit_abort_o) bad++;
        @(posedge clk); #1;
      end
      check_eq("flw_quiet", 64'(bad), 64'd0);
    end
    check_eq("flw_result_kept", 64'(result_o), 64'h2D41);

    // COS, unit never answers: watchdog fires on the 32nd WAIT cycle.
    run_op("cos_to", 2'b11, 32'h1234, 32'h0, 10000, 32'h0, 1'b1, -1, 34, 33);
    check_eq("cos_err", 64'(err_o), 64'd1);
    @(posedge clk); #1; err_clr_i = 1'b1;
    @(posedge clk); #1; err_clr_i = 1'b0;
    @(negedge clk);
    check_eq("err_cleared", 64'(err_o), 64'd0);

    // Done coincides with the watchdog: done wins.
    run_op("done_at_to", 2'b01, 32'd9, 32'd9, 32, 32'h0000_ABCD, 1'b0, -1, 34, -1);
    check_eq("done_at_to_err", 64'(err_o), 64'd0);

    // err_clr_i in the timeout cycle: set wins.
    run_op("to_clr", 2'b10, 32'd5, 32'd0, 10000, 32'h0, 1'b1, 33, 34, 33);
    check_eq("to_clr_err", 64'(err_o), 64'd1);

    // Reset mid-WAIT clears everything at once.
    rsp_delay = 10000;
    @(posedge clk); #1; req_i = 1'b1; op_i = 2'b01; a_i = 32'h77; b_i = 32'h88;
    repeat (4) @(posedge clk);
    #1;
    check_eq("pre_rst_stall", 64'(stall_o), 64'd1);
    rst_n = 1'b0; req_i = 1'b0; op_i = 2'b00;
    #1;
    check_eq("mid_rst_ctrl",
             64'({stall_o, unit_start_o, unit_abort_o, result_valid_o, err_o}), 64'd0);
    check_eq("mid_rst_op", 64'(unit_op_o), 64'd0);
    check_eq("mid_rst_a", 64'(unit_a_o), 64'd0);
    check_eq("mid_rst_b", 64'(unit_b_o), 64'd0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;

    run_op("mul2", 2'b01, 32'd3, 32'd5, 2, 32'd15, 1'b0, -1, 4, -1);

    repeat (3) @(posedge clk);
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_multicycle_ctrl.md
Name: exe_multicycle_ctrl

Overview:
Sequencer for the shared iterative MUL/SIN/COS unit in the execute stage. It accepts a multi-cycle operation from decode/execute control and latches the operands. It launches the unit, stalls the pipeline until the unit finishes, times out, or the instruction is flushed. It then presents a one-cycle result to writeback.

Parameters:
DATA_W, 32, operand/result width
MAX_CYCLES, 32, watchdog limit in WAIT before the operation is declared failed (>=2)
CNT_W, 6, watchdog counter width; must satisfy 2**CNT_W > MAX_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_i  input  1  execute stage holds a valid instruction needing the unit
op_i  input  2  00 none, 01 MUL, 10 SIN, 11 COS (SIN/COS when trigControl set)
a_i  input  DATA_W  operand A
b_i  input  DATA_W  operand B (ignored for SIN/COS)
flush_i  input  1  branch flush of execute stage
unit_start_o  output  1  one-cycle launch pulse to iterative unit
unit_abort_o  output  1  one-cycle abort pulse to iterative unit
unit_op_o  output  2  latched op
unit_a_o  output  DATA_W  latched operand A
unit_b_o  output  DATA_W  latched operand B
unit_done_i  input  1  unit result valid (single-cycle pulse)
unit_result_i  input  DATA_W  unit result
stall_o  output  1  hold fetch/decode/execute registers
result_o  output  DATA_W  captured result
result_valid_o  output  1  result available for writeback this cycle
err_o  output  1  sticky timeout flag
err_clr_i  input  1  clears err_o

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; latches, counter and err_o cleared. Reset mid-operation abandons the operation silently. unit_abort_o is not pulsed.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Acceptance condition: req_i=1, op_i!=00 and flush_i=0.
  - When accepted: latch op_i, a_i and b_i; go to ISSUE.
  - stall_o is combinational and equals the acceptance condition, so the requesting instruction is held from its first cycle.
  - unit_done_i is ignored in IDLE.
- ISSUE:
  - unit_start_o=1 and stall_o=1; counter cleared; go to WAIT.
  - If flush_i=1: unit_start_o is suppressed, unit_abort_o=0, go to IDLE.
- WAIT:
  - stall_o=1; counter increments each cycle.
  - On unit_done_i=1: result_o<=unit_result_i; go to DONE.
  - Timeout: if counter==MAX_CYCLES-1 and unit_done_i=0, then result_o<=0, err_o<=1, unit_abort_o=1 this cycle, go to DONE.
  - If done and timeout occur in the same cycle, done wins and no error is raised.
  - flush_i=1 has priority over done and timeout: unit_abort_o=1, go to IDLE, result_o unchanged.
- DONE:
  - stall_o=0; result_valid_o=1 for exactly this cycle, unless flush_i=1, in which case result_valid_o=0.
  - Always go to IDLE.
  - req_i in DONE is the already-serviced held instruction and is ignored, so no back-to-back re-accept.
- Latency: accept at cycle 0, start at cycle 1, done at cycle 1+k, result_valid at cycle 2+k. Stall spans cycles 0..1+k.
- unit_op_o, unit_a_o and unit_b_o stay stable from ISSUE through WAIT. They are held until the next acceptance.
- err_o:
  - Set only by timeout; stays set until err_clr_i=1.
  - err_clr_i and a timeout in the same cycle leave err_o set (set wins).
  - err_o does not block new requests.
- op_i=00 with req_i=1 in IDLE: no action, stall_o=0.

Test Plan:
- MUL, a=7, b=6; unit done 4 cycles after start with 42 -> stall_o high 6 cycles; unit_start_o pulses once at cycle 1; result_valid_o=1 with result_o=42 at cycle 6; err_o=0.
- SIN, a=0x4000; done with 0x2D41 -> unit_op_o=10; result_o=0x2D41; held req_i during DONE does not retrigger (unit_start_o pulses once only).
- COS with unit never done, MAX_CYCLES=32 -> abort pulse at 32nd WAIT cycle; err_o=1; result_valid_o=1 with result_o=0; err_clr_i pulse -> err_o=0.
- flush_i in ISSUE -> no start pulse, stall_o drops next cycle; flush_i mid-WAIT -> unit_abort_o pulse, no result_valid_o; late unit_done_i in IDLE ignored.
- done on the same cycle as the timeout -> result captured, err_o stays 0; err_clr_i on a timeout cycle -> err_o=1.
- rst_n low mid-WAIT -> all outputs 0 immediately (async); after release, MUL 3x5 completes normally with result_o=15.
